iir_sample_sched: RTL and testbench

IIR_SAMPLE_SCHED -- requirements
Module: iir_sample_sched

---
 rtl/iir_sample_sched.sv | 152 +++++++++++++++
 tb/tb_iir_sample_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sample_sched.sv
// Sample scheduler feeding an ap_ctrl_hs IIR core: paces samples from a tick divider, generates stimulus, captures results.
// Latency: x loaded on the issuing tick, ap_start from the next cycle; y/y_valid one cycle after ap_done.
// Backpressure: ap_start and x are held until ap_ready; ticks arriving while a transaction is open are dropped and counted.
module iir_sample_sched #(
    parameter int DW    = 20,
    parameter int DIV_W = 10,
    parameter int IMP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    input  logic [DW-1:0]    amp,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic [DW-1:0]    x,
    input  logic [DW-1:0]    ap_return,
    output logic [DW-1:0]    y,
    output logic             y_valid,
    output logic [15:0]      overrun_cnt,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] MODE_IMP  = 2'd0;
    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_SQR  = 2'd2;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

    // Assert asynchronously, release two clocks later so no flop sees a release near an edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    logic unused_status;
    assign unused_status = ap_idle;

    logic [1:0]       state;
    logic [IMP_W-1:0] n;
    logic [DIV_W-1:0] tick_cnt;
    logic             run_q;
    logic             tick;
    logic             idle;
    logic             src_ok;
    logic             issue;
    logic             drop;
    logic [DW-1:0]    neg_amp;
    logic [DW-1:0]    stim;

    // run_q holds the counter in reload for the first enabled cycle, so the first tick lands period+1 clocks in.
    assign tick    = enable & run_q & (tick_cnt == '0);
    assign idle    = (state == ST_IDLE);
    assign src_ok  = (mode != 2'd3) | s_valid;
    assign issue   = idle & tick & src_ok;
    assign drop    = ~idle & tick & src_ok;
    assign s_ready = idle & enable & tick & s_valid & (mode == 2'd3);
    assign ap_start = (state == ST_START);
    assign busy     = ~idle;

    always_comb begin
        neg_amp = (amp == MIN_NEG) ? MAX_POS : ({DW{1'b0}} - amp);
        case (mode)
            MODE_IMP:  stim = (n == '0) ? amp : '0;
            MODE_STEP: stim = amp;
            MODE_SQR:  stim = n[IMP_W-1] ? neg_amp : amp;
            default:   stim = s_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            run_q    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            run_q <= enable;
            if (!enable || !run_q || tick) begin
                tick_cnt <= period;
            end else begin
                tick_cnt <= tick_cnt - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= ST_IDLE;
            n           <= '0;
            x           <= '0;
            y           <= '0;
            y_valid     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            y_valid <= 1'b0;

            if (!enable) begin
                n <= '0;
            end else if (issue) begin
                n <= n + IMP_W'(1);
            end

            if (drop && overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end

            if (!idle && ap_done) begin
                y       <= ap_return;
                y_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        x     <= stim;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (ap_ready) begin
                        state <= ap_done ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ap_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_sample_sched.sv
// Bench for iir_sample_sched: a timed behavioural IIR core plus a transaction-level reference of sample issue,
// overrun accounting and result capture, checked every cycle.
`timescale 1ns/1ps
module tb_iir_sample_sched;
    localparam int DW    = 20;
    localparam int DIV_W = 10;
    localparam int IMP_W = 4;
    localparam int NS    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic [DW-1:0]    amp;
    logic [DW-1:0]    s_data;
    logic             s_valid;
    logic             s_ready;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_idle;
    logic [DW-1:0]    x;
    logic [DW-1:0]    ap_return;
    logic [DW-1:0]    y;
    logic             y_valid;
    logic [15:0]      overrun_cnt;
    logic             busy;

    always #5 clk = ~clk;

    iir_sample_sched #(.DW(DW), .DIV_W(DIV_W), .IMP_W(IMP_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .period(period),
        .amp(amp), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .x(x), .ap_return(ap_return), .y(y), .y_valid(y_valid),
        .overrun_cnt(overrun_cnt), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int per = 0, rdly = 0, ddly = 0;

    // core model state
    int            core_cnt = 0, core_done_at = 0;
    bit            core_pend = 0;
    bit            inj_done = 0;
    logic [DW-1:0] core_x = '0;

    // reference model state
    int            en_c, start_at, ready_at, done_at, idle_at, mn, movr;
    logic [DW-1:0] mx, my, tx_x;

    // observation counters
    int st_run = 0, dut_starts = 0, yv_cnt = 0, sr_cnt = 0;

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] v);
        return v ^ 20'h5A5A5;
    endfunction

    function automatic logic [DW-1:0] stim_ref(input logic [1:0] md, input logic [DW-1:0] a,
                                               input int idx, input logic [DW-1:0] sd);
        int va, nv;
        va = int'($signed(a));
        nv = -va;
        if (nv > (1 << (DW-1)) - 1) nv = (1 << (DW-1)) - 1;
        case (md)
            2'd0:    return (idx == 0) ? a : '0;
            2'd1:    return a;
            2'd2:    return (idx < NS/2) ? a : DW'(nv);
            default: return sd;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        en_c = 0; idle_at = 0; start_at = -100; ready_at = -100; done_at = -100;
        mn = 0; movr = 0; mx = '0; my = '0; tx_x = '0; st_run = 0;
    endtask

    // One clock cycle: drive the core, check this cycle's outputs, advance the reference.
    task automatic step();
        logic tick, busy_e;
        ap_ready  = 1'b0;
        ap_done   = inj_done;
        ap_return = DW'($urandom);
        if (!rst_n) begin
            core_pend = 0; core_cnt = 0;
        end else if (core_pend) begin
            if (cyc == core_done_at) begin
                ap_done = 1'b1; ap_return = core_fn(core_x); core_pend = 0;
            end
        end else if (ap_start) begin
            if (core_cnt == rdly) begin
                ap_ready = 1'b1; core_cnt = 0; core_x = x;
                if (ddly == 0) begin
                    ap_done = 1'b1; ap_return = core_fn(x);
                end else begin
                    core_pend = 1; core_done_at = cyc + ddly;
                end
            end else begin
                core_cnt++;
            end
        end
        ap_idle = !core_pend && !ap_start;
        #1;
        if (!rst_n) model_clear();
        tick   = rst_n && enable && en_c > 0 && (en_c % (per + 1)) == 0;
        busy_e = cyc < idle_at;
        if (cyc == done_at + 1) my = core_fn(tx_x);

        chk("busy", 32'(busy), 32'(busy_e));
        chk("ap_start", 32'(ap_start), 32'(cyc >= start_at && cyc <= ready_at));
        chk("x", 32'(x), 32'(mx));
        chk("y_valid", 32'(y_valid), 32'(cyc == done_at + 1));
        chk("y", 32'(y), 32'(my));
        chk("overrun_cnt", 32'(overrun_cnt), 32'(movr));
        chk("s_ready", 32'(s_ready), 32'(tick && !busy_e && mode == 2'd3 && s_valid));

        if (s_ready) sr_cnt++;
        if (y_valid) yv_cnt++;
        if (ap_start) begin
            if (st_run == 0) dut_starts++;
            st_run++;
        end else if (st_run > 0) begin
            chk("start_len", 32'(st_run), 32'(rdly + 1));
            st_run = 0;
        end

        if (tick && (mode != 2'd3 || s_valid)) begin
            if (busy_e) begin
                if (movr < 65535) movr++;
            end else begin
                mx = stim_ref(mode, amp, mn, s_data);
                tx_x = mx;
                mn = (mn + 1) % NS;
                start_at = cyc + 1; ready_at = start_at + rdly;
                done_at = ready_at + ddly; idle_at = done_at + 1;
            end
        end
        if (!enable) mn = 0;
        en_c = enable ? en_c + 1 : 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) step();
    endtask

    task automatic quiesce();
        enable = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 100 && busy; i++) step();
        run(2);
        chk("quiesce_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int s0, y0, sr0;
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; period = '0; amp = '0;
        s_data = '0; s_valid = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1; ap_return = '0;
        model_clear();
        @(negedge clk);
        run(3);
        rst_n = 1'b1;
        run(4);

        // impulse, wrap of the 16-sample window
        per = 9; period = DIV_W'(per); mode = 2'd0; amp = 20'h10000; rdly = 0; ddly = 3;
        s0 = dut_starts; y0 = yv_cnt; enable = 1'b1;
        run(180);
        chk("impulse_starts", 32'(dut_starts - s0), 32'(17));
        chk("impulse_yvalids", 32'(yv_cnt - y0), 32'(17));
        quiesce();

        // slow ap_ready handshake
        per = 20; period = DIV_W'(per); mode = 2'd1; amp = DW'($urandom); rdly = 4; ddly = 2;
        enable = 1'b1;
        run(70);
        quiesce();

        // overrun with mode changes mid-run
        per = 2; period = DIV_W'(per); mode = 2'd1; amp = DW'($urandom); rdly = 0; ddly = 10;
        enable = 1'b1;
        run(40);
        for (int k = 0; k < 6; k++) begin
            mode = 2'($urandom_range(0, 2));
            amp = DW'($urandom);
            run(7);
        end
        quiesce();

        // square with most-negative amplitude
        per = 5; period = DIV_W'(per); mode = 2'd2; amp = 20'h80000; rdly = 0; ddly = 1;
        enable = 1'b1;
        run(6 * 17 + 3);
        quiesce();

        // external source, s_valid withheld for three ticks
        per = 4; period = DIV_W'(per); mode = 2'd3; rdly = 1; ddly = 1;
        s_valid = 1'b0; s0 = dut_starts; enable = 1'b1;
        run(18);
        chk("ext_no_start", 32'(dut_starts - s0), 32'(0));
        s_valid = 1'b1; s_data = DW'($urandom); sr0 = sr_cnt;
        for (int i = 0; i < 12 && sr_cnt == sr0; i++) step();
        s_valid = 1'b0;
        run(8);
        chk("ext_sready_pulses", 32'(sr_cnt - sr0), 32'(1));
        quiesce();

        // randomized configurations with enable glitches and mode changes
        for (int k = 0; k < 8; k++) begin
            quiesce();
            per = $urandom_range(0, 6); period = DIV_W'(per);
            rdly = $urandom_range(0, 3); ddly = $urandom_range(0, 4);
            mode = 2'($urandom_range(0, 3)); amp = DW'($urandom);
            for (int j = 0; j < 60; j++) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data = DW'($urandom);
                if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
                enable = ($urandom_range(0, 24) != 0);
                step();
            end
        end
        quiesce();

        // reset while waiting on ap_done
        per = 3; period = DIV_W'(per); mode = 2'd1; amp = DW'($urandom); rdly = 0; ddly = 6;
        s0 = dut_starts; enable = 1'b1;
        for (int i = 0; i < 200 && !(dut_starts - s0 >= 2 && cyc > ready_at && cyc <= done_at); i++) step();
        chk("reach_wait_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_ap_start", 32'(ap_start), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_y", 32'(y), 32'(0));
        chk("rst_overrun", 32'(overrun_cnt), 32'(0));
        enable = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(4);
        inj_done = 1;
        step();
        inj_done = 0;
        #1;
        chk("no_yv_after_rst", 32'(y_valid), 32'(0));
        run(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
